// File: rtl/serial_comparator_lsb_if.sv
// Request/response bundle for the LSB-first serial magnitude comparator.
// master drives the request; slave is the comparator side.
interface serial_comparator_lsb_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic             ready;
    logic             done;
    logic             isEqual;
    logic             isGreaterThan;
    logic             isLessThan;

    modport master (
        output start, data_operandA, data_operandB,
        input  ready, done, isEqual, isGreaterThan, isLessThan
    );

    modport slave (
        input  start, data_operandA, data_operandB,
        output ready, done, isEqual, isGreaterThan, isLessThan
    );
endinterface

// File: rtl/serial_comparator_lsb.sv
// Multi-cycle magnitude comparator, one 2-bit digit per cycle, LSB first.
// A differing higher digit always overwrites the verdict from lower digits.
module serial_comparator_lsb #(
    parameter int WIDTH  = 32,
    parameter bit SIGNED = 1'b0
) (
    input  logic                  clock,
    input  logic                  reset,
    serial_comparator_lsb_if.slave bus
);
    localparam int D  = WIDTH / 2;
    localparam int CW = (D > 1) ? $clog2(D) : 1;

    // Inverting both MSBs maps two's-complement order onto unsigned order.
    localparam logic [WIDTH-1:0] SIGN_FLIP = SIGNED ? (WIDTH'(1) << (WIDTH - 1)) : '0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_r, b_r;
    logic [CW-1:0]    cnt;
    logic             eq_r, gt_r;
    logic             last_dig;
    logic             done_r, is_eq_r, is_gt_r, is_lt_r;

    assign last_dig = (cnt == CW'(D - 1));

    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (bus.start) state_nx = S_RUN;
            S_RUN:   if (last_dig)  state_nx = S_DONE;
            S_DONE:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Operands shift right so the digit under test is always bits [1:0].
    always_ff @(posedge clock) begin
        if (reset) begin
            a_r     <= '0;
            b_r     <= '0;
            cnt     <= '0;
            eq_r    <= 1'b1;
            gt_r    <= 1'b0;
            done_r  <= 1'b0;
            is_eq_r <= 1'b1;
            is_gt_r <= 1'b0;
            is_lt_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        a_r  <= bus.data_operandA ^ SIGN_FLIP;
                        b_r  <= bus.data_operandB ^ SIGN_FLIP;
                        eq_r <= 1'b1;
                        gt_r <= 1'b0;
                        cnt  <= '0;
                    end
                end
                S_RUN: begin
                    a_r <= a_r >> 2;
                    b_r <= b_r >> 2;
                    if (a_r[1:0] != b_r[1:0]) begin
                        eq_r <= 1'b0;
                        gt_r <= (a_r[1:0] > b_r[1:0]);
                    end
                    if (!last_dig) cnt <= cnt + CW'(1);
                end
                S_DONE: begin
                    done_r  <= 1'b1;
                    is_eq_r <= eq_r;
                    is_gt_r <= gt_r;
                    is_lt_r <= ~eq_r & ~gt_r;
                end
                default: ;
            endcase
        end
    end

    assign bus.ready         = (state == S_IDLE);
    assign bus.done          = done_r;
    assign bus.isEqual       = is_eq_r;
    assign bus.isGreaterThan = is_gt_r;
    assign bus.isLessThan    = is_lt_r;
endmodule
